// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: parity modes, FSM encoding and
// the default bit period.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 10416;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO: the head entry is presented combinationally and
// reads as zero while empty. A push into a full FIFO is accepted only with a pop.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 2-flop synchronizer, 3-sample majority vote per
// bit, optional parity, 1 or 2 stop bits, show-ahead FIFO with sticky overrun.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          UART_CLK,
    input  logic                          reset,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          data,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic                          overrun,
    input  logic                          err_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [2:0]                    fsm_state
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam int             FW        = DATA_BITS + 2;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  SMP0      = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  SMP1      = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0]  SMP2      = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]     LAST_STOP = 4'(STOP_BITS - 1);

    rx_state_t              state;
    rx_state_t              state_next;
    logic                   rx_meta;
    logic                   rx_s;
    logic [CW-1:0]          cnt;
    logic [3:0]             bit_idx;
    logic                   s0;
    logic                   s1;
    logic                   vote;
    logic                   at_vote;
    logic                   at_wrap;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit;
    logic                   ferr_acc;
    logic                   perr;
    logic                   push;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   ovr_evt;
    logic [FW-1:0]          push_word;
    logic [FW-1:0]          head_word;

    always_ff @(posedge UART_CLK or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // The third sample is the live synchronized value at the vote cycle.
    assign vote    = majority3(s0, s1, rx_s);
    assign at_vote = (cnt == SMP2);
    assign at_wrap = (cnt == CNT_LAST);

    always_ff @(posedge UART_CLK or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        push       = 1'b0;
        case (state)
            ST_IDLE:   if (!rx_s) state_next = ST_START;
            ST_START: begin
                if (at_vote && vote) state_next = ST_IDLE;
                else if (at_wrap)    state_next = ST_DATA;
            end
            ST_DATA: begin
                if (at_wrap && bit_idx == LAST_DATA)
                    state_next = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
            end
            ST_PARITY: if (at_wrap) state_next = ST_STOP;
            ST_STOP: begin
                if (at_vote && bit_idx == LAST_STOP) begin
                    state_next = ST_IDLE;
                    push       = 1'b1;
                end
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge UART_CLK or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            bit_idx  <= '0;
            s0       <= 1'b1;
            s1       <= 1'b1;
            shreg    <= '0;
            par_bit  <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            cnt <= (state == ST_IDLE || at_wrap) ? '0 : cnt + 1'b1;
            // Bit index restarts on every state change and counts bit-period wraps.
            if (state_next != state) bit_idx <= '0;
            else if (at_wrap)        bit_idx <= bit_idx + 1'b1;
            if (cnt == SMP0) s0 <= rx_s;
            if (cnt == SMP1) s1 <= rx_s;
            if (state == ST_IDLE) ferr_acc <= 1'b0;
            if (at_vote) begin
                case (state)
                    ST_DATA:   shreg   <= {vote, shreg[DATA_BITS-1:1]};
                    ST_PARITY: par_bit <= vote;
                    ST_STOP:   if (!vote) ferr_acc <= 1'b1;
                    default:   ;
                endcase
            end
        end
    end

    assign perr = (PARITY == PARITY_NONE) ? 1'b0
                : ((^shreg) ^ par_bit ^ (PARITY == PARITY_ODD));
    assign push_word = {perr, ferr_acc | ~vote, shreg};
    assign ovr_evt   = push & fifo_full & ~data_ready;

    always_ff @(posedge UART_CLK or posedge reset) begin
        if (reset)        overrun <= 1'b0;
        else if (ovr_evt) overrun <= 1'b1;
        else if (err_clr) overrun <= 1'b0;
    end

    uart_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (UART_CLK),
        .rst     (reset),
        .push    (push),
        .pop     (data_ready),
        .wr_data (push_word),
        .rd_data (head_word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign {parity_err, frame_err, data} = head_word;
    assign data_valid = ~fifo_empty;
    assign fsm_state  = state;

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10416, UART_CLK cycles per bit; legal range is 8 or more.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal range is 5..9.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1, stop bits checked per frame; legal values are 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4, receive FIFO entries; power of two, 2 or more.
REQ-006 UART_CLK  in  1  sole clock; all logic on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 rx  in  1  serial line, idle high, LSB first.
REQ-009 data  out  DATA_BITS  FIFO head data; valid only while data_valid=1.
REQ-010 frame_err  out  1  FIFO head: a stop bit was sampled low.
REQ-011 parity_err  out  1  FIFO head: parity mismatch; always 0 when PARITY=0.
REQ-012 data_valid  out  1  FIFO not empty.
REQ-013 data_ready  in  1  consumer pop; a pop occurs when data_valid and data_ready are both 1.
REQ-014 overrun  out  1  sticky flag: a frame was dropped because the FIFO was full.
REQ-015 err_clr  in  1  clears overrun on the next rising edge.
REQ-016 fifo_count  out  $clog2(FIFO_DEPTH)+1  current number of entries.

Function
REQ-017 rx SHALL pass through a 2-flop synchronizer; both flops reset to 1, and all logic uses only the synchronized value.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-019 In IDLE, a synchronized 0 SHALL move the FSM to START and zero the bit counter.
REQ-020 Each bit SHALL be sampled by majority vote of three samples at counter values H-1, H, H+1, where H=CLKS_PER_BIT/2 (integer division).
REQ-021 In START, a majority of 1 SHALL reject the event as a glitch and return to IDLE with no push.
REQ-022 The counter SHALL wrap at CLKS_PER_BIT-1; the bit index SHALL advance on each wrap.
REQ-023 DATA SHALL shift in exactly DATA_BITS bits, LSB first.
REQ-024 PARITY SHALL compare the XOR of data bits and parity bit against the expected value: 0 for even, 1 for odd.
REQ-025 STOP SHALL sample STOP_BITS bits; frame_err SHALL be set if any stop majority is 0.
REQ-026 After the last stop-bit vote (cycle N), the FSM SHALL enter IDLE at N+1 and be able to detect a new start at N+1.
REQ-027 A frame SHALL be pushed at edge N+1 as {parity_err, frame_err, data}, errored frames included; data_valid SHALL be 1 at N+1 if the FIFO was empty.
REQ-028 Push while full without a simultaneous pop SHALL drop the frame and set overrun.
REQ-029 Push and pop in the same cycle while full SHALL accept the push; overrun stays unchanged and count is unchanged.
REQ-030 A pop while empty SHALL be ignored; count SHALL never underflow.
REQ-031 The FIFO SHALL be show-ahead: data, frame_err and parity_err reflect the head entry with no read latency.
REQ-032 err_clr and an overrun event in the same cycle: overrun SHALL end at 1 (set wins).

Reset
REQ-033 On reset assertion, the FSM SHALL go to IDLE, counters and FIFO pointers SHALL clear, and data_valid, overrun and fifo_count SHALL be 0.
REQ-034 A frame in progress when reset asserts SHALL be discarded; reception SHALL resume only on a fresh falling edge after reset deasserts.
REQ-035 data, frame_err and parity_err SHALL be 0 after reset.

Structure
REQ-036 Shared package uart_pkg SHALL hold parity-mode constants, the FSM state encoding, and the default CLKS_PER_BIT of 10416.
REQ-037 The FIFO SHALL be the sub-module uart_rx_fifo (parameters WIDTH and DEPTH, with push, pop, full, empty and count).

Verification (CLKS_PER_BIT=16)
REQ-038 8N1 frame 0xA5 -> data=0xA5, both error flags 0, data_valid rises exactly 1 cycle after the stop-bit mid-sample.
REQ-039 Low pulse of 4 cycles on an idle line -> no push, FSM back in IDLE, fifo_count=0.
REQ-040 PARITY=1, frame 0x03 sent with parity bit 1 -> parity_err=1, data=0x03.
REQ-041 Stop bit driven 0 on 0x55 -> frame_err=1 and the entry is still pushed; the next valid frame is received cleanly.
REQ-042 FIFO_DEPTH=4, data_ready=0, five frames -> fifo_count=4, overrun=1, head=first frame; err_clr -> overrun=0.
REQ-043 reset asserted mid-DATA of frame 0x3C -> no push; the following frame 0x81 is received correctly.
